// File: rtl/inst_queue_if.sv
// Fetch/decode bundle of the instruction queue.
//   flush                     : backend flush, empties the queue
//   fetch_valid/addr/date/part/nadr [lane] : up to four in-order fetched instructions
//   queue_full                : fewer than four free entries, fetch must hold
//   req_inst_port [lane]      : decode consumes head+lane this cycle
//   out_valid/in_inst_* [lane]: head+lane entry (fields zero when not valid)
//   queue_empty               : no entries held
// Lane 0 in every 4-bit vector or array corresponds to port/lane 1.
// master = fetch/decode side, slave = queue.
interface inst_queue_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              flush;
  logic [3:0]        fetch_valid;
  logic [ADDR_W-1:0] fetch_addr [4];
  logic [DATA_W-1:0] fetch_date [4];
  logic [3:0]        fetch_part;
  logic [ADDR_W-1:0] fetch_nadr [4];
  logic              queue_full;
  logic [3:0]        req_inst_port;
  logic [3:0]        out_valid;
  logic [ADDR_W-1:0] in_inst_addr [4];
  logic [DATA_W-1:0] in_inst_date [4];
  logic [3:0]        in_inst_part;
  logic [ADDR_W-1:0] in_inst_nadr [4];
  logic              queue_empty;

  modport master (
    output flush, fetch_valid, fetch_addr, fetch_date, fetch_part, fetch_nadr, req_inst_port,
    input  queue_full, out_valid, in_inst_addr, in_inst_date, in_inst_part, in_inst_nadr,
           queue_empty
  );

  modport slave (
    input  flush, fetch_valid, fetch_addr, fetch_date, fetch_part, fetch_nadr, req_inst_port,
    output queue_full, out_valid, in_inst_addr, in_inst_date, in_inst_part, in_inst_nadr,
           queue_empty
  );
endinterface

// File: rtl/inst_queue.sv
// 4-wide instruction FIFO between fetch and decode.
//   clk : clock, all state updates on the rising edge
//   rst : asynchronous active-high reset, empties the queue
//   bus : inst_queue_if slave (fetch push lanes, decode pop lanes, full/empty, flush)
// Entries hold PC, instruction word, predicted-taken bit and predicted next PC.
// Head entries are read combinationally from the register array.
module inst_queue #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  inst_queue_if.slave    bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  // Extra MSB is the wrap bit so that full (count == DEPTH) differs from empty.
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] FULL_THR = PTR_W'(DEPTH - 4);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] date_mem [DEPTH];
  logic [DEPTH-1:0]  part_mem;
  logic [ADDR_W-1:0] nadr_mem [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] count;
  logic [2:0]       push;
  logic [2:0]       pop;

  assign count           = tail_q - head_q;
  // Free entries < 4, judged on the pre-cycle count; a same-cycle pop never helps.
  assign bus.queue_full  = count > FULL_THR;
  assign bus.queue_empty = count == '0;

  // Head read ports; lane data is zeroed when the lane holds no entry.
  for (genvar n = 0; n < 4; n++) begin : g_rd
    logic [IDX_W-1:0] idx;
    assign idx                 = head_q[IDX_W-1:0] + IDX_W'(n);
    assign bus.out_valid[n]    = count > PTR_W'(n);
    assign bus.in_inst_addr[n] = bus.out_valid[n] ? addr_mem[idx] : '0;
    assign bus.in_inst_date[n] = bus.out_valid[n] ? date_mem[idx] : '0;
    assign bus.in_inst_part[n] = bus.out_valid[n] ? part_mem[idx] : 1'b0;
    assign bus.in_inst_nadr[n] = bus.out_valid[n] ? nadr_mem[idx] : '0;
  end

  // Only the leading run of valid lanes is pushed; a gap ends the bundle.
  always_comb begin
    logic run;
    push = 3'd0;
    run  = ~bus.queue_full;
    for (int k = 0; k < 4; k++) begin
      run = run & bus.fetch_valid[k];
      if (run) push = push + 3'd1;
    end
  end

  // Pops stop at the first lane that is not both requested and valid.
  always_comb begin
    logic run;
    pop = 3'd0;
    run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run = run & bus.req_inst_port[k] & bus.out_valid[k];
      if (run) pop = pop + 3'd1;
    end
  end

  always_comb begin
    head_d = head_q + PTR_W'(pop);
    tail_d = tail_q + PTR_W'(push);
    if (bus.flush) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Entry array is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < push) begin
          addr_mem[tail_q[IDX_W-1:0] + IDX_W'(k)] <= bus.fetch_addr[k];
          date_mem[tail_q[IDX_W-1:0] + IDX_W'(k)] <= bus.fetch_date[k];
          part_mem[tail_q[IDX_W-1:0] + IDX_W'(k)] <= bus.fetch_part[k];
          nadr_mem[tail_q[IDX_W-1:0] + IDX_W'(k)] <= bus.fetch_nadr[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue. Lane 0 of each vector is port 1.
// Pushed entries use date = ~pc, part = pc[2], nadr = pc + 0x40.
module tb_inst_queue;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  inst_queue_if #(.ADDR_W(32), .DATA_W(32)) qif ();

  inst_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (qif)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    qif.flush         = 1'b0;
    qif.fetch_valid   = 4'b0000;
    qif.fetch_part    = 4'b0000;
    qif.req_inst_port = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      qif.fetch_addr[k] = '0;
      qif.fetch_date[k] = '0;
      qif.fetch_nadr[k] = '0;
    end
  endtask

  task automatic set_lane(input int k, input logic [31:0] pc);
    qif.fetch_valid[k] = 1'b1;
    qif.fetch_addr[k]  = pc;
    qif.fetch_date[k]  = ~pc;
    qif.fetch_part[k]  = pc[2];
    qif.fetch_nadr[k]  = pc + 32'h40;
  endtask

  task automatic push_bundle(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) set_lane(k, base + 32'(4 * k));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr_in();
    #12;
    vectors++;
    if (qif.queue_empty !== 1'b1) begin
      miscompares++; $display("FAIL rst_empty: got %b want 1", qif.queue_empty);
    end
    vectors++;
    if (qif.queue_full !== 1'b0) begin
      miscompares++; $display("FAIL rst_full: got %b want 0", qif.queue_full);
    end
    vectors++;
    if (qif.out_valid !== 4'b0000) begin
      miscompares++; $display("FAIL rst_valid: got %b want 0000", qif.out_valid);
    end
    vectors++;
    if (qif.in_inst_addr[0] !== 32'h0) begin
      miscompares++; $display("FAIL rst_addr: got %h want 0", qif.in_inst_addr[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    vectors++;
    if (qif.queue_empty !== 1'b1 || qif.queue_full !== 1'b0) begin
      miscompares++;
      $display("FAIL post_rst_flags: got empty=%b full=%b want 1 0", qif.queue_empty,
               qif.queue_full);
    end
    vectors++;
    if (qif.out_valid !== 4'b0000 || qif.in_inst_addr[0] !== 32'h0) begin
      miscompares++;
      $display("FAIL post_rst_out: got valid=%b addr=%h want 0000 0", qif.out_valid,
               qif.in_inst_addr[0]);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp;
    push_bundle(32'h1C00_0000, 4);
    step(); clr_in();
    vectors++;
    if (qif.out_valid !== 4'b1111) begin
      miscompares++; $display("FAIL basic_valid: got %b want 1111", qif.out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      exp = 32'h1C00_0000 + 32'(4 * k);
      vectors++;
      if (qif.in_inst_addr[k] !== exp || qif.in_inst_date[k] !== ~exp ||
          qif.in_inst_part[k] !== exp[2] || qif.in_inst_nadr[k] !== exp + 32'h40) begin
        miscompares++;
        $display("FAIL basic_lane%0d: got %h/%h/%b/%h want %h/%h/%b/%h", k,
                 qif.in_inst_addr[k], qif.in_inst_date[k], qif.in_inst_part[k],
                 qif.in_inst_nadr[k], exp, ~exp, exp[2], exp + 32'h40);
      end
    end
    qif.req_inst_port = 4'b0011;
    step(); clr_in();
    vectors++;
    if (qif.out_valid !== 4'b0011 || qif.in_inst_addr[0] !== 32'h1C00_0008 ||
        qif.in_inst_addr[1] !== 32'h1C00_000C) begin
      miscompares++;
      $display("FAIL basic_pop2: got valid=%b a1=%h a2=%h want 0011 1c000008 1c00000c",
               qif.out_valid, qif.in_inst_addr[0], qif.in_inst_addr[1]);
    end
    // Requests beyond the two held entries must not underflow.
    qif.req_inst_port = 4'b1111;
    step(); clr_in();
    vectors++;
    if (qif.queue_empty !== 1'b1 || qif.out_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL basic_drain: got empty=%b valid=%b want 1 0000", qif.queue_empty,
               qif.out_valid);
    end
  endtask

  task automatic test_full();
    for (int b = 0; b < 4; b++) begin
      push_bundle(32'h2000_0000 + 32'(16 * b), 4);
      step(); clr_in();
      if (b == 2) begin
        vectors++;
        if (qif.queue_full !== 1'b0) begin
          miscompares++; $display("FAIL full_at12: got %b want 0", qif.queue_full);
        end
      end
    end
    vectors++;
    if (qif.queue_full !== 1'b1) begin
      miscompares++; $display("FAIL full_at16: got %b want 1", qif.queue_full);
    end
    push_bundle(32'h3000_0000, 4);
    step(); clr_in();
    vectors++;
    if (qif.queue_full !== 1'b1 || qif.in_inst_addr[0] !== 32'h2000_0000) begin
      miscompares++;
      $display("FAIL full_drop: got full=%b a1=%h want 1 20000000", qif.queue_full,
               qif.in_inst_addr[0]);
    end
    // Pop 4 alongside a push: the push stays blocked by the pre-cycle full.
    push_bundle(32'h3000_0100, 4);
    qif.req_inst_port = 4'b1111;
    step(); clr_in();
    vectors++;
    if (qif.queue_full !== 1'b0 || qif.in_inst_addr[0] !== 32'h2000_0010) begin
      miscompares++;
      $display("FAIL full_pop4: got full=%b a1=%h want 0 20000010", qif.queue_full,
               qif.in_inst_addr[0]);
    end
    for (int c = 0; c < 2; c++) begin
      qif.req_inst_port = 4'b1111;
      step(); clr_in();
      vectors++;
      if (qif.in_inst_addr[0] !== 32'h2000_0020 + 32'(16 * c)) begin
        miscompares++;
        $display("FAIL full_head%0d: got %h want %h", c, qif.in_inst_addr[0],
                 32'h2000_0020 + 32'(16 * c));
      end
    end
    vectors++;
    if (qif.in_inst_addr[3] !== 32'h2000_003C || qif.out_valid !== 4'b1111) begin
      miscompares++;
      $display("FAIL full_tail: got a4=%h valid=%b want 2000003c 1111", qif.in_inst_addr[3],
               qif.out_valid);
    end
    qif.req_inst_port = 4'b1111;
    step(); clr_in();
    vectors++;
    if (qif.queue_empty !== 1'b1) begin
      miscompares++; $display("FAIL full_drain: got %b want 1", qif.queue_empty);
    end
  endtask

  task automatic test_noncontig();
    set_lane(0, 32'h5000_0000);
    set_lane(2, 32'h5000_0008);
    set_lane(3, 32'h5000_000C);
    step(); clr_in();
    vectors++;
    if (qif.out_valid !== 4'b0001 || qif.in_inst_addr[0] !== 32'h5000_0000) begin
      miscompares++;
      $display("FAIL nc_push: got valid=%b a1=%h want 0001 50000000", qif.out_valid,
               qif.in_inst_addr[0]);
    end
    push_bundle(32'h5000_0100, 3);
    step(); clr_in();
    vectors++;
    if (qif.out_valid !== 4'b1111 || qif.in_inst_addr[3] !== 32'h5000_0108) begin
      miscompares++;
      $display("FAIL nc_fill: got valid=%b a4=%h want 1111 50000108", qif.out_valid,
               qif.in_inst_addr[3]);
    end
    qif.req_inst_port = 4'b1101;
    step(); clr_in();
    vectors++;
    if (qif.out_valid !== 4'b0111 || qif.in_inst_addr[0] !== 32'h5000_0100) begin
      miscompares++;
      $display("FAIL nc_pop1: got valid=%b a1=%h want 0111 50000100", qif.out_valid,
               qif.in_inst_addr[0]);
    end
    qif.req_inst_port = 4'b1111;
    step(); clr_in();
    vectors++;
    if (qif.queue_empty !== 1'b1) begin
      miscompares++; $display("FAIL nc_drain: got %b want 1", qif.queue_empty);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    qif.flush = 1'b1;
    step(); clr_in();
    for (int b = 0; b < 3; b++) begin
      push_bundle(32'h3800_0000 + 32'(16 * b), 4);
      step(); clr_in();
    end
    push_bundle(32'h3800_0030, 2);
    step(); clr_in();
    for (int c = 0; c < 3; c++) begin
      qif.req_inst_port = 4'b1111;
      step(); clr_in();
    end
    vectors++;
    if (qif.out_valid !== 4'b0011 || qif.in_inst_addr[0] !== 32'h3800_0030) begin
      miscompares++;
      $display("FAIL wrap_pre: got valid=%b a1=%h want 0011 38000030", qif.out_valid,
               qif.in_inst_addr[0]);
    end
    // Tail sits at index 14: this bundle lands in 14,15,0,1.
    push_bundle(32'h4000_0000, 4);
    step(); clr_in();
    vectors++;
    if (qif.out_valid !== 4'b1111 || qif.in_inst_addr[1] !== 32'h3800_0034 ||
        qif.in_inst_addr[2] !== 32'h4000_0000) begin
      miscompares++;
      $display("FAIL wrap_mix: got valid=%b a2=%h a3=%h want 1111 38000034 40000000",
               qif.out_valid, qif.in_inst_addr[1], qif.in_inst_addr[2]);
    end
    qif.req_inst_port = 4'b0011;
    step(); clr_in();
    for (int k = 0; k < 4; k++) begin
      exp = 32'h4000_0000 + 32'(4 * k);
      vectors++;
      if (qif.in_inst_addr[k] !== exp || qif.in_inst_date[k] !== ~exp ||
          qif.in_inst_part[k] !== exp[2] || qif.in_inst_nadr[k] !== exp + 32'h40) begin
        miscompares++;
        $display("FAIL wrap_lane%0d: got %h/%h/%b/%h want %h/%h/%b/%h", k,
                 qif.in_inst_addr[k], qif.in_inst_date[k], qif.in_inst_part[k],
                 qif.in_inst_nadr[k], exp, ~exp, exp[2], exp + 32'h40);
      end
    end
    qif.req_inst_port = 4'b1111;
    step(); clr_in();
    vectors++;
    if (qif.queue_empty !== 1'b1) begin
      miscompares++; $display("FAIL wrap_drain: got %b want 1", qif.queue_empty);
    end
  endtask

  task automatic test_flush();
    push_bundle(32'h6000_0000, 4);
    step(); clr_in();
    push_bundle(32'h6100_0000, 4);
    qif.req_inst_port = 4'b1111;
    qif.flush         = 1'b1;
    #1;
    vectors++;
    if (qif.out_valid !== 4'b1111 || qif.in_inst_addr[0] !== 32'h6000_0000) begin
      miscompares++;
      $display("FAIL flush_during: got valid=%b a1=%h want 1111 60000000", qif.out_valid,
               qif.in_inst_addr[0]);
    end
    step(); clr_in();
    vectors++;
    if (qif.queue_empty !== 1'b1 || qif.out_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL flush_after: got empty=%b valid=%b want 1 0000", qif.queue_empty,
               qif.out_valid);
    end
    push_bundle(32'h6200_0000, 1);
    step(); clr_in();
    vectors++;
    if (qif.out_valid !== 4'b0001 || qif.in_inst_addr[0] !== 32'h6200_0000) begin
      miscompares++;
      $display("FAIL flush_refill: got valid=%b a1=%h want 0001 62000000", qif.out_valid,
               qif.in_inst_addr[0]);
    end
    qif.req_inst_port = 4'b0001;
    step(); clr_in();
  endtask

  task automatic test_reset_mid();
    push_bundle(32'h7000_0000, 4);
    step(); clr_in();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (qif.queue_empty !== 1'b1 || qif.queue_full !== 1'b0 || qif.out_valid !== 4'b0000 ||
        qif.in_inst_addr[0] !== 32'h0) begin
      miscompares++;
      $display("FAIL rstmid_clear: got empty=%b full=%b valid=%b a1=%h want 1 0 0000 0",
               qif.queue_empty, qif.queue_full, qif.out_valid, qif.in_inst_addr[0]);
    end
    push_bundle(32'h7100_0000, 4);
    step();
    #1 rst = 1'b0;
    step(); clr_in();
    vectors++;
    if (qif.out_valid !== 4'b1111 || qif.in_inst_addr[0] !== 32'h7100_0000) begin
      miscompares++;
      $display("FAIL rstmid_push: got valid=%b a1=%h want 1111 71000000", qif.out_valid,
               qif.in_inst_addr[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_noncontig();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
